lsu: RTL and testbench

- Load/store unit directly downstream of the RV64 ALU.
- Takes the ALU result as the effective address and rs2 as store data.
- Performs one aligned data-bus transaction per request through a valid/ready front end and a req/gnt/rvalid memory bus.
- Returns sign- or zero-extended load data to write-back.
- Misaligned and illegal accesses are detected locally and never reach the bus.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu.sv | 171 +++++++++++++++++
 tb/tb_lsu.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit.
// Access sizes, error codes and FSM states.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      RESP
   } state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit.
// Shifts store data into lanes and extends load data.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  off,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [63:0] wdata,
   input  logic [63:0] rdata,
   output logic [63:0] wdata_sh,
   output logic [7:0]  wmask,
   output logic [63:0] rdata_ext
);

   logic [5:0]  bsh;
   logic [63:0] sh;
   logic [7:0]  base;

   assign bsh      = {off, 3'b000};
   assign wdata_sh = wdata << bsh;
   assign sh       = rdata >> bsh;
   assign wmask    = base << off;

   // byte-enable pattern of the access before the lane shift
   always_comb begin
      base = 8'h01;
      case (size)
         SZ_B:    base = 8'h01;
         SZ_H:    base = 8'h03;
         SZ_W:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
   end

   // keep the low bytes of the shifted word and extend to 64 bits
   always_comb begin
      rdata_ext = sh;
      case (size)
         SZ_B: rdata_ext = uns ? {56'b0, sh[7:0]}
                               : {{56{sh[7]}}, sh[7:0]};
         SZ_H: rdata_ext = uns ? {48'b0, sh[15:0]}
                               : {{48{sh[15]}}, sh[15:0]};
         SZ_W: rdata_ext = uns ? {32'b0, sh[31:0]}
                               : {{32{sh[31]}}, sh[31:0]};
         default: rdata_ext = sh;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one aligned bus transaction per request.
// Local misalign/illegal detection, timeout on REQ+WAIT.
module lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 256,
   parameter int ADDR_W  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [63:0]       in_wdata,
   input  logic              in_is_load,
   input  logic              in_is_store,
   input  logic [2:0]        in_funct3,
   output logic              bus_req,
   input  logic              bus_gnt,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [63:0]       bus_wdata,
   output logic [7:0]        bus_wmask,
   input  logic              bus_rvalid,
   input  logic [63:0]       bus_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [63:0]       out_rdata,
   output logic [1:0]        out_err
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [63:0]       wdata_q, wdata_d;
   logic [2:0]        f3_q, f3_d;
   logic              ld_q, ld_d;
   logic              st_q, st_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [63:0]       rdata_q, rdata_d;
   logic [1:0]        err_q, err_d;

   logic              ill;
   logic              mis;
   logic              in_req;
   logic              at_lim;
   logic [63:0]       wdata_sh;
   logic [7:0]        wmask;
   logic [63:0]       rdata_ext;

   assign ill = (in_is_load && in_is_store)
             || (in_is_store && in_funct3[2])
             || (in_is_load && in_funct3 == 3'b111);

   assign mis = (in_funct3[1:0] == SZ_H && in_addr[0])
             || (in_funct3[1:0] == SZ_W && |in_addr[1:0])
             || (in_funct3[1:0] == SZ_D && |in_addr[2:0]);

   assign in_req = (state_q == REQ);
   assign at_lim = (cnt_q == LIM);

   lsu_align u_align (
      .off       (addr_q[2:0]),
      .size      (f3_q[1:0]),
      .uns       (f3_q[2]),
      .wdata     (wdata_q),
      .rdata     (bus_rdata),
      .wdata_sh  (wdata_sh),
      .wmask     (wmask),
      .rdata_ext (rdata_ext)
   );

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == RESP);
   assign out_rdata = rdata_q;
   assign out_err   = err_q;
   assign bus_req   = in_req;
   assign bus_we    = in_req & st_q;
   assign bus_addr  = in_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
   assign bus_wdata = in_req ? wdata_sh : '0;
   assign bus_wmask = in_req ? wmask : '0;

   // next-state, request latches, timeout counter and response
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      ld_d    = ld_q;
      st_d    = st_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               addr_d  = in_addr;
               wdata_d = in_wdata;
               f3_d    = in_funct3;
               ld_d    = in_is_load;
               st_d    = in_is_store;
               cnt_d   = '0;
               rdata_d = '0;
               err_d   = ERR_OK;
               if (ill) begin
                  state_d = RESP;
                  err_d   = ERR_ILLEGAL;
               end else if (!in_is_load && !in_is_store) begin
                  state_d = RESP;
               end else if (mis) begin
                  state_d = RESP;
                  err_d   = ERR_MISALIGN;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            cnt_d = at_lim ? cnt_q : cnt_q + CW'(1);
            if (bus_gnt) begin
               state_d = st_q ? RESP : WAIT;
            end else if (at_lim) begin
               state_d = RESP;
               err_d   = ERR_TIMEOUT;
            end
         end
         WAIT: begin
            cnt_d = at_lim ? cnt_q : cnt_q + CW'(1);
            if (bus_rvalid) begin
               state_d = RESP;
               rdata_d = rdata_ext;
            end else if (at_lim) begin
               state_d = RESP;
               err_d   = ERR_TIMEOUT;
            end
         end
         RESP: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         ld_q    <= 1'b0;
         st_q    <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= ERR_OK;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         ld_q    <= ld_d;
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: byte-level reference model,
// per-cycle comparison and directed transactions.
module tb_lsu;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_addr = '0;
   logic [63:0] in_wdata = '0;
   logic        in_is_load = 1'b0;
   logic        in_is_store = 1'b0;
   logic [2:0]  in_funct3 = '0;
   logic        bus_req;
   logic        bus_gnt = 1'b0;
   logic        bus_we;
   logic [63:0] bus_addr;
   logic [63:0] bus_wdata;
   logic [7:0]  bus_wmask;
   logic        bus_rvalid = 1'b0;
   logic [63:0] bus_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_rdata;
   logic [1:0]  out_err;

   int n_pass = 0;
   int n_tot  = 0;

   // reference expectations for the transaction in flight
   bit          m_busy = 0;
   bit          m_bus;
   bit          m_st;
   int          m_lat;
   int          m_reqlen;
   logic [1:0]  m_err;
   logic [63:0] m_rdata;
   logic [63:0] m_ea;
   logic [63:0] m_wd;
   logic [7:0]  m_wm;

   int cyc = 0;
   int m_acc = 0;
   int t_gnt, t_rv, t_rdy;
   int req_seen, resp_seen, gnt_cyc;
   bit hs = 0;
   int got_lat;
   logic [63:0] got_rdata, got_addr, got_wd;
   logic [7:0]  got_wm;
   logic [1:0]  got_err;

   always #5 clk = ~clk;

   lsu #(.TIMEOUT(T), .ADDR_W(64)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_addr     (in_addr),
      .in_wdata    (in_wdata),
      .in_is_load  (in_is_load),
      .in_is_store (in_is_store),
      .in_funct3   (in_funct3),
      .bus_req     (bus_req),
      .bus_gnt     (bus_gnt),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_wmask   (bus_wmask),
      .bus_rvalid  (bus_rvalid),
      .bus_rdata   (bus_rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_rdata   (out_rdata),
      .out_err     (out_err)
   );

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [1:0] m_err_f(logic [63:0] a, logic ld,
                                          logic st, logic [2:0] f3);
      int n;
      n = 1 << f3[1:0];
      if ((ld && st) || (st && f3[2]) || (ld && f3 == 3'b111)) return 2'b11;
      if (!ld && !st) return 2'b00;
      if ((int'(a[2:0]) % n) != 0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [7:0] m_mask_f(logic [1:0] sz, int off);
      logic [7:0] m;
      int n;
      n = 1 << sz;
      m = '0;
      for (int i = 0; i < 8; i++) m[i] = (i >= off) && (i < off + n);
      return m;
   endfunction

   function automatic logic [63:0] m_wdata_f(logic [63:0] wd, int off);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 8; i++)
         if (i >= off) r[8*i +: 8] = wd[8*(i-off) +: 8];
      return r;
   endfunction

   function automatic logic [63:0] m_load_f(logic [63:0] rd, int off,
                                            logic [2:0] f3);
      logic [63:0] v;
      int n;
      n = 1 << f3[1:0];
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
      if (!f3[2] && n < 8 && v[8*n-1])
         for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic compare();
      int rel;
      logic er, eo;
      rel = cyc - m_acc;
      er = m_busy && m_bus && rel >= 1 && rel <= m_reqlen;
      eo = m_busy && rel >= m_lat;
      chk("in_ready", in_ready, !m_busy);
      chk("bus_req", bus_req, er);
      chk("out_valid", out_valid, eo);
      if (er && bus_req) begin
         chk("bus_addr", bus_addr, m_ea);
         chk("bus_we", bus_we, m_st);
         if (m_st) begin
            chk("bus_wdata", bus_wdata, m_wd);
            chk("bus_wmask", bus_wmask, m_wm);
         end
      end
      if (eo && out_valid) begin
         chk("out_rdata", out_rdata, m_rdata);
         chk("out_err", out_err, m_err);
      end
   endtask

   task automatic drive_bus();
      int rel;
      rel = cyc - m_acc;
      if (bus_req) begin
         if (req_seen == 0) begin
            got_addr = bus_addr;
            got_wd   = bus_wdata;
            got_wm   = bus_wmask;
         end
         if (req_seen == t_gnt) begin
            bus_gnt = 1'b1;
            gnt_cyc = rel;
         end
         req_seen++;
      end
      if (gnt_cyc >= 0 && !m_st && rel == gnt_cyc + t_rv) bus_rvalid = 1'b1;
      if (out_valid) begin
         if (resp_seen == 0) got_lat = rel;
         if (resp_seen == t_rdy) begin
            out_ready = 1'b1;
            hs        = 1;
            got_rdata = out_rdata;
            got_err   = out_err;
         end
         resp_seen++;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      if (hs) begin
         m_busy    = 0;
         out_ready = 1'b0;
         hs        = 0;
      end
      compare();
      if (m_busy) drive_bus();
   endtask

   task automatic setup(logic [63:0] a, logic [63:0] wd, logic ld, logic st,
                        logic [2:0] f3, int gd, int rv, logic [63:0] rd,
                        int rdy);
      int off;
      off      = int'(a[2:0]);
      m_err    = m_err_f(a, ld, st, f3);
      m_bus    = (m_err == 2'b00) && (ld || st);
      m_st     = st;
      m_ea     = {a[63:3], 3'b000};
      m_wd     = m_wdata_f(wd, off);
      m_wm     = m_mask_f(f3[1:0], off);
      m_rdata  = '0;
      m_reqlen = 0;
      m_lat    = 1;
      if (m_bus) begin
         if (gd < 0) begin
            m_reqlen = T;
            m_lat    = T + 1;
            m_err    = 2'b10;
         end else if (st) begin
            m_reqlen = gd + 1;
            m_lat    = gd + 2;
         end else begin
            m_reqlen = gd + 1;
            m_lat    = gd + rv + 2;
            m_rdata  = m_load_f(rd, off, f3);
         end
      end
      t_gnt     = gd;
      t_rv      = rv;
      t_rdy     = rdy;
      bus_rdata = rd;
      in_addr     = a;
      in_wdata    = wd;
      in_is_load  = ld;
      in_is_store = st;
      in_funct3   = f3;
   endtask

   task automatic accept();
      tick();
      in_valid  = 1'b1;
      m_busy    = 1;
      m_acc     = cyc;
      req_seen  = 0;
      resp_seen = 0;
      gnt_cyc   = -1;
      got_lat   = -1;
      got_rdata = 'x;
      got_err   = 'x;
      got_addr  = 'x;
      got_wd    = 'x;
      got_wm    = 'x;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic run(string nm, logic [63:0] a, logic [63:0] wd, logic ld,
                      logic st, logic [2:0] f3, int gd, int rv,
                      logic [63:0] rd, int rdy);
      setup(a, wd, ld, st, f3, gd, rv, rd, rdy);
      accept();
      for (int k = 0; k < 100 && m_busy; k++) tick();
      if (m_busy) begin
         chk({nm, " completes"}, 64'd0, 64'd1);
         m_busy    = 0;
         out_ready = 1'b0;
         hs        = 0;
      end
      chk({nm, " latency"}, got_lat, m_lat);
      chk({nm, " requests"}, req_seen, m_reqlen);
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst in_ready", in_ready, 1'b1);
      chk("rst bus_req", bus_req, 1'b0);
      chk("rst out_valid", out_valid, 1'b0);
      chk("rst out_rdata", out_rdata, 64'd0);
      chk("rst out_err", out_err, 2'b00);
      chk("rst bus_we", bus_we, 1'b0);
      chk("rst bus_wmask", bus_wmask, 8'h00);
      chk("rst bus_addr", bus_addr, 64'd0);
      rst = 1'b0;

      run("lw", 64'h8000_0004, 64'd0, 1, 0, 3'b010, 0, 2,
          64'h8765_4321_1234_5678, 0);
      chk("lw rdata", got_rdata, 64'hFFFF_FFFF_8765_4321);
      chk("lw err", got_err, 2'b00);
      chk("lw addr", got_addr, 64'h8000_0000);
      chk("lw lat", got_lat, 4);

      run("sh", 64'h8000_0006, 64'h1234_5678_9ABC_BEEF, 0, 1, 3'b001,
          3, 0, 64'd0, 0);
      chk("sh reqs", req_seen, 4);
      chk("sh wdata", got_wd, 64'hBEEF_0000_0000_0000);
      chk("sh wmask", got_wm, 8'hC0);
      chk("sh err", got_err, 2'b00);

      run("lw mis", 64'h8000_0002, 64'd0, 1, 0, 3'b010, 0, 1, 64'd0, 0);
      chk("mis err", got_err, 2'b01);
      chk("mis rdata", got_rdata, 64'd0);
      chk("mis lat", got_lat, 1);
      chk("mis reqs", req_seen, 0);

      run("tmo", 64'h8000_0008, 64'd0, 1, 0, 3'b010, -1, 1, 64'd0, 0);
      chk("tmo err", got_err, 2'b10);
      chk("tmo lat", got_lat, 17);
      chk("tmo reqs", req_seen, 16);
      chk("tmo rdata", got_rdata, 64'd0);

      run("sd", 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 0, 1, 3'b011,
          0, 0, 64'd0, 0);
      chk("sd wmask", got_wm, 8'hFF);
      chk("sd lat", got_lat, 2);

      run("lbu", 64'h8000_0007, 64'd0, 1, 0, 3'b100, 0, 1,
          64'hFF00_0000_0000_0000, 3);
      chk("lbu rdata", got_rdata, 64'h0000_0000_0000_00FF);
      chk("lbu lat", got_lat, 3);

      run("lb", 64'h8000_0007, 64'd0, 1, 0, 3'b000, 1, 1,
          64'hFF00_0000_0000_0000, 0);
      chk("lb rdata", got_rdata, 64'hFFFF_FFFF_FFFF_FFFF);

      run("lh", 64'h8000_000A, 64'd0, 1, 0, 3'b001, 0, 1,
          64'h1111_2222_8001_3333, 1);
      chk("lh rdata", got_rdata, 64'hFFFF_FFFF_FFFF_8001);

      run("ldst", 64'h8000_0000, 64'd0, 1, 1, 3'b010, 0, 1, 64'd0, 0);
      chk("ldst err", got_err, 2'b11);
      run("sbu", 64'h8000_0000, 64'd0, 0, 1, 3'b100, 0, 1, 64'd0, 0);
      chk("sbu err", got_err, 2'b11);
      run("l111", 64'h8000_0000, 64'd0, 1, 0, 3'b111, 0, 1, 64'd0, 0);
      chk("l111 err", got_err, 2'b11);

      run("nop", 64'h8000_0003, 64'd5, 0, 0, 3'b011, 0, 1, 64'd0, 0);
      chk("nop err", got_err, 2'b00);
      chk("nop lat", got_lat, 1);

      run("sb", 64'h8000_0005, 64'h0000_0000_0000_00AA, 0, 1, 3'b000,
          1, 0, 64'd0, 0);
      chk("sb wmask", got_wm, 8'h20);
      chk("sb wdata", got_wd, 64'h0000_AA00_0000_0000);

      run("ld", 64'h8000_0018, 64'd0, 1, 0, 3'b011, 2, 3,
          64'hDEAD_BEEF_CAFE_F00D, 0);
      chk("ld rdata", got_rdata, 64'hDEAD_BEEF_CAFE_F00D);

      run("sw mis", 64'h8000_0001, 64'd0, 0, 1, 3'b010, 0, 0, 64'd0, 0);
      chk("sw mis err", got_err, 2'b01);

      // asynchronous reset while waiting for read data
      setup(64'h8000_0020, 64'd0, 1, 0, 3'b010, 0, 1000, 64'h1234, 0);
      accept();
      tick();
      #2 rst = 1'b1;
      #1;
      chk("arst bus_req", bus_req, 1'b0);
      chk("arst out_valid", out_valid, 1'b0);
      chk("arst in_ready", in_ready, 1'b1);
      m_busy = 0;
      @(negedge clk);
      rst = 1'b0;
      tick();
      bus_rvalid = 1'b1;
      bus_gnt    = 1'b1;
      tick();
      tick();
      tick();
      chk("late rvalid out_valid", out_valid, 1'b0);

      run("lwu", 64'h8000_0004, 64'd0, 1, 0, 3'b110, 0, 1,
          64'h8765_4321_0000_0000, 0);
      chk("lwu rdata", got_rdata, 64'h0000_0000_8765_4321);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
